// File: rtl/sram_arb_pkg.sv
// Shared types, host index constants and the round-robin selection helper for the
// SRAM bus arbiter.
package sram_arb_pkg;

  // Upper bound on the number of hosts; host_id_t is sized for it.
  localparam int unsigned MaxHosts = 8;

  typedef logic [2:0] host_id_t;

  localparam host_id_t HostIdxInstr = 3'd0;
  localparam host_id_t HostIdxData  = 3'd1;
  localparam host_id_t HostIdxDbg   = 3'd2;

  // First requesting host at or after ptr, searching upward and wrapping after last.
  // Unused upper request bits must be zero. Returns 0 when nobody requests.
  function automatic host_id_t rr_pick(input logic [MaxHosts-1:0] req, input host_id_t ptr,
                                       input host_id_t last);
    host_id_t idx;
    host_id_t pick;
    logic     found;
    idx   = ptr;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MaxHosts; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == last) ? '0 : idx + host_id_t'(1);
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of host IDs for granted-but-unresponded SRAM transactions.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_id     enqueue the ID of a newly granted host
//   pop               dequeue the head (ignored when empty)
//   head              ID of the oldest outstanding transaction
//   empty, full       occupancy flags
// Push and pop may coincide, including when full (the pop frees the slot).
module sram_arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  host_id_t push_id,
  input  logic     pop,
  output host_id_t head,
  output logic     empty,
  output logic     full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  host_id_t        mem_q [Depth];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign head    = mem_q[rd_q];
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_comb begin
    rd_d  = pop_en  ? ptr_inc(rd_q) : rd_q;
    wr_d  = push_en ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_q] <= push_id;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one single-port SRAM between NumHosts req/gnt/rvalid bus hosts.
// Round-robin selection, zero-latency grant pass-through, up to MaxOutstanding
// transactions in flight, responses routed back to the issuing host in order.
// Optional build macro: SRAM_ARB_DATA_PRIO_EN -- host 1 (core data) wins whenever it
// requests; the remaining hosts stay round-robin.
// Ports:
//   clk_sys_i, rst_sys_ni                   clock, asynchronous active-low reset
//   host_req_i/we_i/be_i/addr_i/wdata_i     packed per-host request channel
//   host_gnt_o, host_rvalid_o               per-host grant / response valid
//   host_rdata_o, host_err_o                shared response data, qualified by rvalid
//   dev_req_o/we_o/be_o/addr_o/wdata_o      SRAM request channel
//   dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i   SRAM handshake and response
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NumHosts       = 3,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_sys_ni,
  input  logic [NumHosts-1:0]           host_req_i,
  input  logic [NumHosts-1:0]           host_we_i,
  input  logic [NumHosts*4-1:0]         host_be_i,
  input  logic [NumHosts*AddrWidth-1:0] host_addr_i,
  input  logic [NumHosts*32-1:0]        host_wdata_i,
  output logic [NumHosts-1:0]           host_gnt_o,
  output logic [NumHosts-1:0]           host_rvalid_o,
  output logic [31:0]                   host_rdata_o,
  output logic                          host_err_o,
  output logic                          dev_req_o,
  output logic                          dev_we_o,
  output logic [3:0]                    dev_be_o,
  output logic [AddrWidth-1:0]          dev_addr_o,
  output logic [31:0]                   dev_wdata_o,
  input  logic                          dev_gnt_i,
  input  logic                          dev_rvalid_i,
  input  logic [31:0]                   dev_rdata_i,
  input  logic                          dev_err_i
);

  localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
  localparam host_id_t    LastHost = host_id_t'(NumHosts - 1);

  logic [MaxHosts-1:0] req_pad;
  host_id_t            winner, ptr_q, ptr_d, fifo_head;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic                can_issue, grant, pop, fifo_empty, fifo_full;

  always_comb begin
    req_pad                 = '0;
    req_pad[NumHosts-1:0]   = host_req_i;
  end

  always_comb begin
`ifdef SRAM_ARB_DATA_PRIO_EN
    if (req_pad[HostIdxData]) begin
      winner = HostIdxData;
    end else begin
      winner = rr_pick(req_pad, ptr_q, LastHost);
    end
`else
    winner = rr_pick(req_pad, ptr_q, LastHost);
`endif
  end

  // A response retiring this cycle frees its slot for a same-cycle issue.
  assign can_issue = (outstanding_q < CntW'(MaxOutstanding)) | dev_rvalid_i;
  assign dev_req_o = (|host_req_i) & can_issue;
  assign grant     = dev_req_o & dev_gnt_i;
  // Responses with nothing outstanding (e.g. after reset) are dropped.
  assign pop       = dev_rvalid_i & ~fifo_empty;

  assign host_rdata_o = dev_rdata_i;
  assign host_err_o   = dev_err_i;

  always_comb begin
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    for (int unsigned h = 0; h < NumHosts; h++) begin
      if (dev_req_o && (winner == host_id_t'(h))) begin
        dev_we_o      = host_we_i[h];
        dev_be_o      = host_be_i[h*4 +: 4];
        dev_addr_o    = host_addr_i[h*AddrWidth +: AddrWidth];
        dev_wdata_o   = host_wdata_i[h*32 +: 32];
        host_gnt_o[h] = dev_gnt_i;
      end
      if (pop && (fifo_head == host_id_t'(h))) begin
        host_rvalid_o[h] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (winner == LastHost) ? '0 : winner + host_id_t'(1);
    end
    outstanding_d = outstanding_q;
    unique case ({grant, pop})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      ptr_q         <= '0;
      outstanding_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

  sram_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk     (clk_sys_i),
    .rst_n   (rst_sys_ni),
    .push    (grant),
    .push_id (winner),
    .pop     (pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifndef SYNTHESIS
  stray_rvalid_a : assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      dev_rvalid_i |-> !fifo_empty)
    else $warning("sram_bus_arbiter: dropped SRAM response with nothing outstanding");

  count_sync_a : assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      (outstanding_q == CntW'(MaxOutstanding)) == fifo_full);
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter (NumHosts=3, MaxOutstanding=2).
// A queue-based reference model predicts grants, routing and pass-through data
// every cycle; directed steps then random traffic drive it.
module tb_sram_bus_arbiter;

  localparam int NH = 3;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NH-1:0] host_req, host_we, host_gnt, host_rvalid;
  logic [NH*4-1:0]  host_be;
  logic [NH*32-1:0] host_addr, host_wdata;
  logic [31:0]   host_rdata, dev_addr, dev_wdata, dev_rdata;
  logic          host_err, dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
  logic [3:0]    dev_be;

  sram_bus_arbiter #(
    .NumHosts       (NH),
    .AddrWidth      (32),
    .MaxOutstanding (MO)
  ) dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_n),
    .host_req_i    (host_req),
    .host_we_i     (host_we),
    .host_be_i     (host_be),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_gnt_o    (host_gnt),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
    .dev_req_o     (dev_req),
    .dev_we_o      (dev_we),
    .dev_be_o      (dev_be),
    .dev_addr_o    (dev_addr),
    .dev_wdata_o   (dev_wdata),
    .dev_gnt_i     (dev_gnt),
    .dev_rvalid_i  (dev_rvalid),
    .dev_rdata_i   (dev_rdata),
    .dev_err_i     (dev_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
  } ent_t;

  ent_t        q[$];
  int          glog[$];
  int          ptr;
  int          rem[NH];
  logic        hwe[NH];
  logic [3:0]  hbe[NH];
  logic [31:0] haddr[NH];
  logic [31:0] hwd[NH];
  bit          gnt_always, stray, err_force;
  int          rv_mode;  // 0 never, 1 whenever outstanding, 2 random when outstanding
  int          n_assert = 0;
  int          n_fail = 0;
  logic        snap_we, snap_err;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wdata, snap_rdata;
  logic [NH-1:0] snap_rvalid;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_payload(input int h);
    hwe[h]   = 1'($urandom_range(0, 1));
    hbe[h]   = 4'($urandom_range(1, 15));
    haddr[h] = 32'($urandom_range(0, 255)) << 2;
    hwd[h]   = $urandom();
  endtask

  // Reference winner: data-priority first when enabled, else first requester from ptr.
  function automatic int pick();
`ifdef SRAM_ARB_DATA_PRIO_EN
    if (rem[1] > 0) return 1;
`endif
    for (int j = 0; j < NH; j++) begin
      if (rem[(ptr + j) % NH] > 0) return (ptr + j) % NH;
    end
    return 0;
  endfunction

  task automatic drive();
    for (int h = 0; h < NH; h++) begin
      host_req[h]            = (rem[h] > 0);
      host_we[h]             = hwe[h];
      host_be[h*4 +: 4]      = hbe[h];
      host_addr[h*32 +: 32]  = haddr[h];
      host_wdata[h*32 +: 32] = hwd[h];
    end
    dev_gnt = gnt_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (stray) dev_rvalid = 1'b1;
    else if (rv_mode == 1) dev_rvalid = (q.size() > 0);
    else if (rv_mode == 2) dev_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
    else dev_rvalid = 1'b0;
    dev_rdata = (q.size() > 0) ? mem_val(q[0].addr) : $urandom();
    dev_err   = err_force ? 1'b1 : ((rv_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0);
  endtask

  // One clock: drive, compare at negedge, advance model at posedge.
  task automatic cycle();
    int            w;
    logic          dreq, grant;
    logic [NH-1:0] eg, er;
    drive();
    @(negedge clk);
    w     = pick();
    dreq  = (host_req != '0) && ((q.size() < MO) || dev_rvalid);
    grant = dreq && dev_gnt;
    eg    = grant ? NH'(1 << w) : '0;
    er    = (dev_rvalid && q.size() > 0) ? NH'(1 << q[0].id) : '0;
    check("gnt", host_gnt, eg);
    check("rvalid", host_rvalid, er);
    check("dev_req", dev_req, dreq);
    if (dreq) begin
      check("dev_we", dev_we, hwe[w]);
      check("dev_be", dev_be, hbe[w]);
      check("dev_addr", dev_addr, haddr[w]);
      check("dev_wdata", dev_wdata, hwd[w]);
    end
    if (er != '0) begin
      check("rdata", host_rdata, mem_val(q[0].addr));
      check("err", host_err, dev_err);
    end
    for (int h = 0; h < NH; h++) if (host_gnt[h]) glog.push_back(h);
    snap_we = dev_we; snap_be = dev_be; snap_addr = dev_addr; snap_wdata = dev_wdata;
    snap_rvalid = host_rvalid; snap_err = host_err; snap_rdata = host_rdata;
    @(posedge clk);
    if (rst_n) begin
      if (er != '0) void'(q.pop_front());
      if (grant) begin
        q.push_back('{w, haddr[w]});
        ptr = (w + 1) % NH;
        rem[w]--;
        new_payload(w);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int h = 0; h < NH; h++) rem[h] = 0;
    q.delete();
    ptr = 0; rv_mode = 0; stray = 1'b0; err_force = 1'b0; gnt_always = 1'b1;
    repeat (2) cycle();
    check("rst_dev_we", dev_we, 1'b0);
    check("rst_dev_addr", dev_addr, 32'h0);
    check("rst_dev_wdata", dev_wdata, 32'h0);
    check("rst_dev_be", dev_be, 4'h0);
    rst_n = 1'b1;
    glog.delete();
  endtask

  task automatic drain();
    for (int h = 0; h < NH; h++) rem[h] = 0;
    rv_mode = 1;
    for (int i = 0; i < 8 && q.size() > 0; i++) cycle();
    check("drain_empty", host_rvalid, '0);
  endtask

  initial begin
    for (int h = 0; h < NH; h++) new_payload(h);
    #2;
    do_reset();

    // Single host read of 0x100, response one cycle after grant.
    hwe[0] = 1'b0; hbe[0] = 4'hF; haddr[0] = 32'h100; rem[0] = 1; rv_mode = 1;
    cycle();
    check("t1_gnt_order", glog.size(), 1);
    cycle();
    check("t1_rvalid", snap_rvalid, 3'b001);
    check("t1_rdata", snap_rdata, mem_val(32'h100));
    cycle();

    // All three hosts continuously: 0,1,2,0,1,2.
    do_reset();
    rv_mode = 1;
    for (int h = 0; h < NH; h++) rem[h] = 2;
    repeat (6) cycle();
    check("t2_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_order", (glog.size() > i) ? glog[i] : 99, i % 3);
    drain();

    // No responses for 4 cycles: only MO grants, then back-pressure.
    do_reset();
    rem[0] = 3; rem[2] = 3; rv_mode = 0;
    repeat (4) cycle();
    check("t3_grants_held", glog.size(), 2);
    check("t3_req_blocked", dev_req, 1'b0);
    rv_mode = 1;
    repeat (4) cycle();
    check("t3_grants_after", glog.size(), 6);
    drain();

    // Pointer parked at 2 with hosts 0 and 1 requesting.
    do_reset();
    rem[1] = 1; rv_mode = 1;
    repeat (2) cycle();
    glog.delete();
    rem[0] = 1; rem[1] = 1;
    repeat (3) cycle();
`ifdef SRAM_ARB_DATA_PRIO_EN
    check("t4_first", (glog.size() > 0) ? glog[0] : 99, 1);
    check("t4_second", (glog.size() > 1) ? glog[1] : 99, 0);
`else
    check("t4_first", (glog.size() > 0) ? glog[0] : 99, 0);
    check("t4_second", (glog.size() > 1) ? glog[1] : 99, 1);
`endif
    drain();

    // Reset with two outstanding, then a stray response.
    do_reset();
    rem[0] = 2; rv_mode = 0;
    repeat (2) cycle();
    check("t5_outstanding", glog.size(), 2);
    do_reset();
    stray = 1'b1;
    cycle();
    stray = 1'b0;
    check("t5_stray_rvalid", snap_rvalid, '0);
    rem[0] = 3;
    repeat (3) cycle();
    check("t5_count_cleared", glog.size(), 2);
    drain();

    // Host 2 write with error response.
    do_reset();
    hwe[2] = 1'b1; hbe[2] = 4'b0011; haddr[2] = 32'h204; hwd[2] = 32'hDEADBEEF;
    rem[2] = 1; rv_mode = 0;
    cycle();
    check("t6_we", snap_we, 1'b1);
    check("t6_be", snap_be, 4'b0011);
    check("t6_addr", snap_addr, 32'h204);
    check("t6_wdata", snap_wdata, 32'hDEADBEEF);
    err_force = 1'b1; rv_mode = 1;
    cycle();
    check("t6_rvalid", snap_rvalid, 3'b100);
    check("t6_err", snap_err, 1'b1);
    err_force = 1'b0;
    drain();

    // Random traffic with random device grant/response timing.
    do_reset();
    gnt_always = 1'b0; rv_mode = 2;
    for (int i = 0; i < 400; i++) begin
      for (int h = 0; h < NH; h++) begin
        if (rem[h] == 0 && $urandom_range(0, 3) == 0) rem[h] = $urandom_range(1, 3);
      end
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares the demo system's single-port SRAM between NumHosts bus hosts over an Ibex-style req/gnt/rvalid interface.
- Default host mapping: 0 = core instruction fetch, 1 = core data, 2 = debug module system bus.
- Round-robin arbitration with pipelined grants, up to MaxOutstanding in flight.
- Each response is routed back to the issuing host in order.

Parameters:
- NumHosts, 3, number of requesting hosts (2..8).
- AddrWidth, 32, byte address width.
- MaxOutstanding, 2, maximum granted-but-unresponded transactions (1..4).

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  asynchronous active-low reset.
- host_req_i  input  NumHosts  per-host request.
- host_we_i  input  NumHosts  per-host write enable.
- host_be_i  input  NumHosts*4  per-host byte enables.
- host_addr_i  input  NumHosts*AddrWidth  per-host address.
- host_wdata_i  input  NumHosts*32  per-host write data.
- host_gnt_o  output  NumHosts  per-host grant, one-hot or zero.
- host_rvalid_o  output  NumHosts  per-host response valid.
- host_rdata_o  output  32  read data, shared by all hosts; qualified by host_rvalid_o.
- host_err_o  output  1  error, shared by all hosts; qualified by host_rvalid_o.
- dev_req_o  output  1  SRAM request.
- dev_we_o  output  1  SRAM write enable.
- dev_be_o  output  4  SRAM byte enables.
- dev_addr_o  output  AddrWidth  SRAM address.
- dev_wdata_o  output  32  SRAM write data.
- dev_gnt_i  input  1  SRAM grant.
- dev_rvalid_i  input  1  SRAM response valid.
- dev_rdata_i  input  32  SRAM read data.
- dev_err_i  input  1  SRAM error.

Behaviour:
- Reset values:
  - host_gnt_o, host_rvalid_o, dev_req_o, dev_we_o = 0.
  - Data and address outputs = 0.
  - Round-robin pointer = 0.
  - Outstanding count = 0; ID FIFO empty.
- Selection (combinational):
  - Winner = first requesting host at or after the pointer, searching upward and wrapping past NumHosts-1.
  - dev_* outputs are muxed from the winner in the same cycle.
  - dev_req_o = any host_req_i AND can_issue.
- can_issue = (outstanding < MaxOutstanding) OR dev_rvalid_i.
  - A response retiring in the same cycle frees a slot, giving back-to-back throughput.
- Grant: host_gnt_o[winner] = dev_gnt_i AND dev_req_o. Zero latency from dev_gnt_i.
- On each grant:
  - Winner ID is pushed into the ID FIFO.
  - Pointer moves to winner+1, wrapping to 0 after NumHosts-1.
  - Without a grant, the pointer holds.
- Outstanding count:
  - +1 on grant only; -1 on dev_rvalid_i only; unchanged when both occur in the same cycle.
- Response routing:
  - On dev_rvalid_i, host_rvalid_o[FIFO head] = 1 and the FIFO pops.
  - host_rdata_o and host_err_o pass through combinationally from dev_rdata_i and dev_err_i.
  - Responses are strictly in grant order.
- Request stability: a host holds req and its payload until granted; the arbiter does not check this.
- dev_rvalid_i with an empty FIFO: ignored, with no host rvalid. Simulation assertion fires.
- Full FIFO with no rvalid: dev_req_o = 0, all grants 0, pointer frozen.
- Reset mid-transaction: FIFO and count clear immediately; late SRAM responses are dropped per the empty-FIFO rule.

Optional Feature:
- Macro: SRAM_ARB_DATA_PRIO_EN.
- Defined: host 1 (core data) wins whenever it requests, regardless of the pointer.
  - The pointer still advances to 2 after a host 1 grant.
  - All other hosts use round-robin among themselves.
- Undefined: pure round-robin for all hosts.

Decomposition:
- Package sram_arb_pkg holds:
  - host_id_t, sized $clog2(NumHosts max 8) = 3 bits.
  - Constants HostIdxInstr = 0, HostIdxData = 1, HostIdxDbg = 2.
  - The selection helper function.
- One sub-module: sram_arb_id_fifo.
  - Depth MaxOutstanding, width host_id_t.
  - Push/pop allowed in the same cycle, including when full.
  - Outputs: head, empty, full.

Test Plan:
- Single host: host 0 reads 0x100 with the device always granting and rvalid one cycle later.
  - Expect gnt[0] in cycle 0 and rvalid[0] in cycle 1 with rdata = mem[0x100].
  - Outstanding count returns to 0.
- All three hosts request continuously for 6 cycles.
  - Expect grant order 0,1,2,0,1,2 with one grant per cycle.
  - Each rvalid lands on the matching host one cycle later.
- dev_rvalid_i held 0 for 4 cycles while hosts 0 and 2 request.
  - Expect exactly 2 grants, then all gnt = 0 and dev_req_o = 0.
  - After the first rvalid, exactly one new grant per rvalid.
- Pointer at 2, hosts 0 and 1 request: expect host 0 granted first (wrap), then host 1.
  - With SRAM_ARB_DATA_PRIO_EN defined, host 1 is granted first instead.
- rst_sys_ni asserted with 2 outstanding, then deasserted, then one stray dev_rvalid_i pulse.
  - Expect no host_rvalid_o and the count to stay 0.
- Host 2 writes be = 4'b0011 to addr 0x204 with wdata 0xDEADBEEF.
  - Expect the dev_* outputs to match exactly, with dev_we_o = 1 in the grant cycle.
  - rvalid[2] follows with err = dev_err_i.
